div_issue_queue: RTL and testbench

DIV_ISSUE_QUEUE -- requirements
Module: div_issue_queue

---
 rtl/div_issue_queue_if.sv | 40 ++++
 rtl/div_issue_queue.sv | 157 +++++++++++++++
 tb/tb_div_issue_queue.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_issue_queue_if.sv
// Bundle of the division issue queue's dispatch, CDB snoop, flush,
// divider-side and status signals. The queue uses the slave modport; the
// dispatch stage, CDB and divider drive it through the master modport.
interface div_issue_queue_if;
  logic        disp_en;
  logic [2:0]  disp_funct3;
  logic [5:0]  disp_tag;
  logic [31:0] disp_op1;
  logic [31:0] disp_op2;
  logic        disp_op1_valid;
  logic        disp_op2_valid;
  logic [5:0]  disp_op1_tag;
  logic [5:0]  disp_op2_tag;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        flush;
  logic        div_busy;
  logic        queue_en;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [2:0]  funct3;
  logic [5:0]  tag_out;
  logic        full;
  logic [2:0]  count;

  modport slave (
    input  disp_en, disp_funct3, disp_tag, disp_op1, disp_op2,
           disp_op1_valid, disp_op2_valid, disp_op1_tag, disp_op2_tag,
           cdb_valid, cdb_tag, cdb_data, flush, div_busy,
    output queue_en, op1, op2, funct3, tag_out, full, count
  );

  modport master (
    output disp_en, disp_funct3, disp_tag, disp_op1, disp_op2,
           disp_op1_valid, disp_op2_valid, disp_op1_tag, disp_op2_tag,
           cdb_valid, cdb_tag, cdb_data, flush, div_busy,
    input  queue_en, op1, op2, funct3, tag_out, full, count
  );
endinterface

// File: rtl/div_issue_queue.sv
// Four-entry age-ordered issue queue for the integer divider. Entries wait
// for their operands on the CDB and issue oldest-ready-first, spaced by a
// cooldown that covers the divider's latency.
//
// Handshake: dispatch is a one-sided write (disp_en) that is silently dropped
// when full=1 or flush=1. Issue is a one-sided strobe: queue_en=1 means the
// divider takes op1/op2/funct3/tag_out this cycle; div_busy and the
// cooldown counter are the only back-pressure.
module div_issue_queue (
  input  logic               clk,
  input  logic               rst,
  div_issue_queue_if.slave   bus
);

  typedef struct packed {
    logic        valid;
    logic [2:0]  funct3;
    logic [5:0]  tag;
    logic [31:0] op1;
    logic        op1_rdy;
    logic [5:0]  op1_tag;
    logic [31:0] op2;
    logic        op2_rdy;
    logic [5:0]  op2_tag;
  } entry_t;

  entry_t     ent_q [4];
  entry_t     ent_d [4];
  entry_t     woken [5];
  entry_t     incoming;
  logic [2:0] cool_q;
  logic [2:0] cool_d;
  logic [2:0] count;
  logic       cand_found;
  logic [1:0] cand_idx;
  logic       issue;
  logic       accept;
  logic [1:0] free_slot;

  // Occupancy from registered valid bits only.
  always_comb begin
    count = 3'd0;
    for (int i = 0; i < 4; i++) begin
      count = count + {2'b00, ent_q[i].valid};
    end
  end

  // Oldest entry whose registered ready flags are both set.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (ent_q[i].valid && ent_q[i].op1_rdy && ent_q[i].op2_rdy) begin
        cand_found = 1'b1;
        cand_idx   = 2'(i);
      end
    end
  end

  assign issue        = cand_found & ~bus.div_busy & (cool_q == 3'd0) & ~bus.flush;
  assign accept       = bus.disp_en & ~bus.full & ~bus.flush;
  assign free_slot    = count[1:0] - {1'b0, issue};

  assign bus.queue_en = issue;
  assign bus.op1      = issue ? ent_q[cand_idx].op1    : 32'd0;
  assign bus.op2      = issue ? ent_q[cand_idx].op2    : 32'd0;
  assign bus.funct3   = issue ? ent_q[cand_idx].funct3 : 3'd0;
  assign bus.tag_out  = issue ? ent_q[cand_idx].tag    : 6'd0;
  assign bus.full     = (count == 3'd4);
  assign bus.count    = count;

  // CDB wakeup of stored entries; slot 4 is an empty filler for the shift.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      woken[i] = ent_q[i];
      if (!ent_q[i].op1_rdy && bus.cdb_valid && (bus.cdb_tag == ent_q[i].op1_tag)) begin
        woken[i].op1_rdy = 1'b1;
        woken[i].op1     = bus.cdb_data;
      end
      if (!ent_q[i].op2_rdy && bus.cdb_valid && (bus.cdb_tag == ent_q[i].op2_tag)) begin
        woken[i].op2_rdy = 1'b1;
        woken[i].op2     = bus.cdb_data;
      end
    end
    woken[4] = '0;
  end

  // Incoming entry, with operands bypassed from a same-cycle CDB broadcast.
  always_comb begin
    incoming         = '0;
    incoming.valid   = 1'b1;
    incoming.funct3  = bus.disp_funct3;
    incoming.tag     = bus.disp_tag;
    incoming.op1_tag = bus.disp_op1_tag;
    incoming.op2_tag = bus.disp_op2_tag;
    incoming.op1     = bus.disp_op1;
    incoming.op2     = bus.disp_op2;
    incoming.op1_rdy = bus.disp_op1_valid;
    incoming.op2_rdy = bus.disp_op2_valid;
    if (!bus.disp_op1_valid && bus.cdb_valid && (bus.cdb_tag == bus.disp_op1_tag)) begin
      incoming.op1_rdy = 1'b1;
      incoming.op1     = bus.cdb_data;
    end
    if (!bus.disp_op2_valid && bus.cdb_valid && (bus.cdb_tag == bus.disp_op2_tag)) begin
      incoming.op2_rdy = 1'b1;
      incoming.op2     = bus.cdb_data;
    end
  end

  // Next queue contents: remove the issued entry, shift younger ones down,
  // then append the dispatch at the first free slot; flush empties all.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (issue && (2'(i) >= cand_idx)) begin
        ent_d[i] = woken[i + 1];
      end else begin
        ent_d[i] = woken[i];
      end
    end
    if (accept) begin
      ent_d[free_slot] = incoming;
    end
    if (bus.flush) begin
      for (int i = 0; i < 4; i++) begin
        ent_d[i] = '0;
      end
    end
  end

  // Cooldown reloads on each issue and counts down otherwise; flush leaves
  // it alone because the in-flight divide still occupies the divider.
  always_comb begin
    if (issue) begin
      cool_d = 3'd5;
    end else if (cool_q != 3'd0) begin
      cool_d = cool_q - 3'd1;
    end else begin
      cool_d = cool_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        ent_q[i] <= '0;
      end
      cool_q <= 3'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        ent_q[i] <= ent_d[i];
      end
      cool_q <= cool_d;
    end
  end

endmodule

// File: tb/tb_div_issue_queue.sv
// Bench for div_issue_queue: directed scenarios for ready issue, cooldown,
// wakeup order, full handling, bypass/flush and mid-run reset, then random
// traffic, all checked every cycle against a queue-based reference model.
module tb_div_issue_queue;

  logic clk;
  logic rst;
  div_issue_queue_if bus ();

  div_issue_queue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0]  f;
    logic [5:0]  tag;
    logic [31:0] v1;
    logic [31:0] v2;
    bit          r1;
    bit          r2;
    logic [5:0]  t1;
    logic [5:0]  t2;
  } m_ent_t;

  m_ent_t      mq[$];
  int          m_cool;
  logic [72:0] exp_q[$];
  int          iss_cyc[$];
  logic [5:0]  iss_tag[$];
  logic [31:0] iss_op2[$];
  int          cyc;
  int          total;
  int          bad;
  int          n0;

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic idle();
    bus.disp_en        = 1'b0;
    bus.disp_funct3    = 3'd0;
    bus.disp_tag       = 6'd0;
    bus.disp_op1       = 32'd0;
    bus.disp_op2       = 32'd0;
    bus.disp_op1_valid = 1'b0;
    bus.disp_op2_valid = 1'b0;
    bus.disp_op1_tag   = 6'd0;
    bus.disp_op2_tag   = 6'd0;
    bus.cdb_valid      = 1'b0;
    bus.cdb_tag        = 6'd0;
    bus.cdb_data       = 32'd0;
    bus.flush          = 1'b0;
    bus.div_busy       = 1'b0;
  endtask

  task automatic disp(input logic [2:0] f, input logic [5:0] tag,
                      input logic [31:0] a, input logic a_ok, input logic [5:0] at,
                      input logic [31:0] b, input logic b_ok, input logic [5:0] bt);
    idle();
    bus.disp_en        = 1'b1;
    bus.disp_funct3    = f;
    bus.disp_tag       = tag;
    bus.disp_op1       = a;
    bus.disp_op1_valid = a_ok;
    bus.disp_op1_tag   = at;
    bus.disp_op2       = b;
    bus.disp_op2_valid = b_ok;
    bus.disp_op2_tag   = bt;
  endtask

  function automatic int m_cand();
    foreach (mq[i]) if (mq[i].r1 && mq[i].r2) return i;
    return -1;
  endfunction

  // One clock: check outputs at the falling edge, advance the model at the
  // rising edge using the inputs held through the cycle.
  task automatic cycle();
    int          idx;
    int          sz;
    bit          exp_en;
    logic [72:0] got_w;
    m_ent_t      n;
    @(negedge clk);
    idx    = m_cand();
    exp_en = (idx >= 0) && !bus.div_busy && (m_cool == 0) && !bus.flush;
    chk("queue_en", bus.queue_en, exp_en);
    chk("count", bus.count, mq.size());
    chk("full", bus.full, mq.size() == 4);
    if (exp_en) exp_q.push_back({mq[idx].f, mq[idx].tag, mq[idx].v1, mq[idx].v2});
    got_w = {bus.funct3, bus.tag_out, bus.op1, bus.op2};
    if (bus.queue_en) begin
      iss_cyc.push_back(cyc);
      iss_tag.push_back(bus.tag_out);
      iss_op2.push_back(bus.op2);
      if (exp_q.size() > 0) chk("issue_word", got_w, exp_q.pop_front());
      else chk("issue_expected", exp_en, 1);
    end else begin
      chk("idle_out", got_w, 0);
    end
    @(posedge clk);
    cyc++;
    sz = mq.size();
    if (bus.flush) begin
      mq.delete();
    end else begin
      if (exp_en) mq.delete(idx);
      foreach (mq[i]) begin
        if (!mq[i].r1 && bus.cdb_valid && bus.cdb_tag == mq[i].t1) begin
          mq[i].r1 = 1; mq[i].v1 = bus.cdb_data;
        end
        if (!mq[i].r2 && bus.cdb_valid && bus.cdb_tag == mq[i].t2) begin
          mq[i].r2 = 1; mq[i].v2 = bus.cdb_data;
        end
      end
      if (bus.disp_en && sz < 4) begin
        n.f   = bus.disp_funct3;
        n.tag = bus.disp_tag;
        n.t1  = bus.disp_op1_tag;
        n.t2  = bus.disp_op2_tag;
        n.v1  = bus.disp_op1;
        n.v2  = bus.disp_op2;
        n.r1  = bus.disp_op1_valid;
        n.r2  = bus.disp_op2_valid;
        if (!n.r1 && bus.cdb_valid && bus.cdb_tag == n.t1) begin n.r1 = 1; n.v1 = bus.cdb_data; end
        if (!n.r2 && bus.cdb_valid && bus.cdb_tag == n.t2) begin n.r2 = 1; n.v2 = bus.cdb_data; end
        mq.push_back(n);
      end
    end
    if (exp_en) m_cool = 5;
    else if (m_cool > 0) m_cool--;
    #1;
  endtask

  task automatic settle(input int n);
    for (int k = 0; k < n; k++) begin
      idle();
      cycle();
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    cyc    = 0;
    m_cool = 0;
    idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_queue_en", bus.queue_en, 0);
    chk("rst_op1", bus.op1, 0);
    chk("rst_op2", bus.op2, 0);
    chk("rst_funct3", bus.funct3, 0);
    chk("rst_tag_out", bus.tag_out, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_count", bus.count, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Ready dispatch issues the next cycle.
    disp(3'd4, 6'd9, 32'd100, 1, 6'd0, 32'd7, 1, 6'd0);
    cycle();
    idle();
    #1;
    chk("r025_en", bus.queue_en, 1);
    chk("r025_op1", bus.op1, 32'd100);
    chk("r025_op2", bus.op2, 32'd7);
    chk("r025_tag", bus.tag_out, 6'd9);
    chk("r025_funct3", bus.funct3, 3'd4);
    cycle();
    chk("r025_count", bus.count, 0);
    settle(6);

    // Two ready entries issue six cycles apart.
    n0 = iss_cyc.size();
    disp(3'd5, 6'd1, 32'd10, 1, 6'd0, 32'd2, 1, 6'd0);
    cycle();
    disp(3'd5, 6'd2, 32'd11, 1, 6'd0, 32'd3, 1, 6'd0);
    cycle();
    settle(8);
    chk("r026_n", iss_cyc.size() - n0, 2);
    if (iss_cyc.size() >= n0 + 2) chk("r026_gap", iss_cyc[n0+1] - iss_cyc[n0], 6);

    // Younger ready entry overtakes one waiting on tag 12.
    disp(3'd5, 6'd10, 32'd1, 1, 6'd0, 32'd0, 0, 6'd12);
    bus.div_busy = 1'b1;
    cycle();
    disp(3'd5, 6'd11, 32'd2, 1, 6'd0, 32'd3, 1, 6'd0);
    bus.div_busy = 1'b1;
    cycle();
    n0 = iss_cyc.size();
    settle(1);
    idle();
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = 6'd12;
    bus.cdb_data  = 32'd3;
    cycle();
    settle(8);
    chk("r027_n", iss_cyc.size() - n0, 2);
    if (iss_cyc.size() >= n0 + 2) begin
      chk("r027_first", iss_tag[n0], 6'd11);
      chk("r027_second", iss_tag[n0+1], 6'd10);
      chk("r027_op2", iss_op2[n0+1], 32'd3);
      chk("r027_gap", iss_cyc[n0+1] - iss_cyc[n0], 6);
    end

    // Fill with waiting entries, reject extras, then refill slot 3.
    disp(3'd6, 6'd13, 32'd0, 0, 6'd31, 32'd1, 1, 6'd0); cycle();
    disp(3'd6, 6'd14, 32'd0, 0, 6'd30, 32'd1, 1, 6'd0); cycle();
    disp(3'd6, 6'd15, 32'd0, 0, 6'd30, 32'd1, 1, 6'd0); cycle();
    disp(3'd6, 6'd16, 32'd0, 0, 6'd30, 32'd1, 1, 6'd0); cycle();
    idle();
    #1;
    chk("r028_full", bus.full, 1);
    chk("r028_count", bus.count, 4);
    disp(3'd6, 6'd20, 32'd5, 1, 6'd0, 32'd1, 1, 6'd0);
    cycle();
    chk("r028_ignored", bus.count, 4);
    idle();
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = 6'd31;
    bus.cdb_data  = 32'h55;
    cycle();
    disp(3'd6, 6'd20, 32'd5, 1, 6'd0, 32'd1, 1, 6'd0);
    cycle();
    chk("r028_issue_full", bus.count, 3);
    disp(3'd6, 6'd20, 32'd5, 1, 6'd0, 32'd1, 1, 6'd0);
    cycle();
    chk("r028_refill", bus.count, 4);
    idle();
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = 6'd30;
    bus.cdb_data  = 32'd9;
    cycle();
    settle(30);
    chk("r028_last", iss_tag[iss_tag.size()-1], 6'd20);

    // Bypass on dispatch, then a flush that leaves the cooldown running.
    disp(3'd7, 6'd21, 32'd0, 0, 6'd5, 32'd8, 1, 6'd0);
    bus.div_busy  = 1'b1;
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = 6'd5;
    bus.cdb_data  = 32'hFFFF_FFFF;
    cycle();
    idle();
    #1;
    chk("r029_en", bus.queue_en, 1);
    chk("r029_op1", bus.op1, 32'hFFFF_FFFF);
    n0 = iss_cyc.size();
    cycle();
    disp(3'd7, 6'd22, 32'd1, 1, 6'd0, 32'd1, 1, 6'd0);
    bus.div_busy = 1'b1;
    cycle();
    idle();
    bus.flush = 1'b1;
    cycle();
    chk("r029_flush_count", bus.count, 0);
    disp(3'd7, 6'd23, 32'd1, 1, 6'd0, 32'd1, 1, 6'd0);
    cycle();
    settle(8);
    chk("r029_n", iss_cyc.size() - n0, 2);
    if (iss_cyc.size() >= n0 + 2) begin
      chk("r029_tag", iss_tag[n0+1], 6'd23);
      chk("r029_gap", iss_cyc[n0+1] - iss_cyc[n0], 6);
    end

    // Reset mid-operation drops entries and the cooldown.
    disp(3'd4, 6'd24, 32'd1, 1, 6'd0, 32'd1, 1, 6'd0);
    cycle();
    settle(1);
    disp(3'd4, 6'd25, 32'd1, 1, 6'd0, 32'd1, 1, 6'd0);
    bus.div_busy = 1'b1;
    cycle();
    idle();
    rst = 1'b0;
    #1;
    chk("r024_count", bus.count, 0);
    chk("r024_en", bus.queue_en, 0);
    mq.delete();
    m_cool = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    disp(3'd4, 6'd26, 32'd1, 1, 6'd0, 32'd1, 1, 6'd0);
    cycle();
    idle();
    #1;
    chk("r024_no_cool", bus.queue_en, 1);
    settle(2);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      bus.disp_en        = 1'($urandom_range(0, 1));
      bus.disp_funct3    = 3'($urandom_range(4, 7));
      bus.disp_tag       = 6'($urandom_range(0, 63));
      bus.disp_op1       = $urandom;
      bus.disp_op2       = $urandom;
      bus.disp_op1_valid = ($urandom_range(0, 9) < 6);
      bus.disp_op2_valid = ($urandom_range(0, 9) < 6);
      bus.disp_op1_tag   = 6'($urandom_range(0, 7));
      bus.disp_op2_tag   = 6'($urandom_range(0, 7));
      bus.cdb_valid      = ($urandom_range(0, 9) < 4);
      bus.cdb_tag        = 6'($urandom_range(0, 7));
      bus.cdb_data       = $urandom;
      bus.div_busy       = ($urandom_range(0, 9) < 2);
      bus.flush          = ($urandom_range(0, 49) == 0);
      cycle();
    end
    settle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
